fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Instruction-fetch/PC stage directly upstream of the opcode decoder.
//  - Holds the PC and fetches a word from instruction memory over a req/ack handshake.
//  - Latches the word into an instruction register and presents it to decode/datapath for one execute cycle.
//  - Consumes the decoder's Branch/Jump/Jal outputs plus ALU zero to compute the next PC.
// PARAMETERS
//  RESET_PC        32'h0040_0000  PC value loaded on reset
//  TIMEOUT_CYCLES  16             FETCH cycles without ack before fetch_error; 0 disables timeout
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  imem_req     out  1   fetch request to instruction memory
//  imem_addr    out  32  fetch address (= pc while imem_req)
//  imem_ack     in   1   memory has imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  instruction register, feeds decoder OP = instr[31:26]
//  instr_valid  out  1   execute cycle: datapath may commit RegWrite/MemWrite
//  pc           out  32  address of instr
//  pc_plus4     out  32  pc + 4, link value for jal
//  stall        in   1   hold execute cycle (e.g. slow data memory)
//  branch       in   1   decoder Branch
//  jump         in   1   decoder Jump
//  jal          in   1   decoder Jal
//  alu_zero     in   1   ALU zero flag for the current instr
//  jr           in   1   jump-register request
//  jr_target    in   32  rs value for jr
//  fetch_error  out  1   sticky error flag; fetching halts until reset
// BEHAVIOUR
//  Reset (any state, any cycle, overrides all inputs):
//   - state=IDLE, pc=RESET_PC, instr=0, fetch_error=0, timeout counter=0.
//   - imem_req=0 and instr_valid=0 during and after the reset cycle.
//   - An imem_ack arriving during reset is ignored.
//  FSM IDLE/FETCH/EXEC/ERROR:
//   - IDLE: one cycle, then FETCH.
//   - FETCH: imem_req=1, imem_addr=pc.
//     - On imem_ack: instr<=imem_rdata, counter<=0, next state EXEC.
//     - Otherwise counter++. When counter reaches TIMEOUT_CYCLES-1 with no ack: ERROR.
//   - EXEC: instr_valid=1, imem_req=0.
//     - stall=1: stay in EXEC, pc/instr hold, instr_valid stays 1.
//     - stall=0: pc<=next_pc, next state FETCH.
//   - ERROR: fetch_error=1, imem_req=0, instr_valid=0; exit only via reset.
//  Latency and throughput:
//   - ack in cycle N => instr_valid high in N+1.
//   - Zero-wait memory (ack same cycle as req) gives 2 cycles per instruction.
//  imem_ack outside FETCH is ignored. imem_rdata is sampled only in the ack cycle.
//  next_pc priority, highest first:
//   1. jr: jr_target. If jr_target[1:0]!=0, go to ERROR instead of FETCH.
//   2. jump|jal: {pc_plus4[31:28], instr[25:0], 2'b00}.
//   3. branch taken: pc_plus4 + {sext(instr[15:0]), 2'b00}.
//      - taken = branch & (instr[26] ? ~alu_zero : alu_zero) (BEQ/BNE differ in opcode bit 26).
//   4. otherwise: pc_plus4.
//  Arithmetic and outputs:
//   - All PC arithmetic is 32-bit modulo, wrapping silently (0xFFFF_FFFC+4 = 0).
//   - pc_plus4 is combinational from pc and is valid in every state.
//   - Control inputs are sampled only in the EXEC cycle with stall=0.
// TESTING
//  1. Reset -> pc=0x0040_0000, imem_req=0 in reset cycle, req=1 two cycles after reset drops; instr_valid=0 throughout.
//  2. Zero-wait ack, instr=0x2008_0005 (addi), no control -> instr_valid every 2nd cycle, pc 0x0040_0000->0x0040_0004.
//  3. beq at pc=0x0040_0010, imm=0xFFFF: alu_zero=1 -> next pc=0x0040_0010; same case with bne, alu_zero=1 -> next pc=0x0040_0014.
//  4. jal 0x0C10_0008 at pc=0x0040_0020 -> pc_plus4=0x0040_0024 during EXEC, next pc=0x0040_0020; jr with jr_target=0x0040_0024 beats simultaneous jump=1.
//  5. Ack withheld 16 cycles -> fetch_error=1, req=0; late ack ignored; reset clears the error. Repeat with ack in cycle 15 -> no error.
//  6. stall=1 for 3 cycles in EXEC -> instr_valid held 3 extra cycles, pc unchanged; reset asserted mid-FETCH with ack -> instr stays 0, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch / PC stage feeding the opcode decoder.
// Fetches over a req/ack handshake and resolves the next PC.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jal,
  input  logic        alu_zero,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        fetch_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERROR = 2'd3
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] timeoutCnt;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic [31:0] jumpTarget;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic        branchTaken;
  logic        jrMisaligned;
  logic        timeoutHit;
  logic        retire;

  assign pcPlus4 = pcReg + 32'd4;

  assign jumpTarget = {pcPlus4[31:28],
                       instrReg[25:0], 2'b00};

  assign branchOffset = {{14{instrReg[15]}},
                         instrReg[15:0], 2'b00};

  assign branchTarget = pcPlus4 + branchOffset;

  // BEQ and BNE differ only in opcode bit 26
  assign branchTaken = branch &
    (instrReg[26] ? ~alu_zero : alu_zero);

  assign jrMisaligned = jr & (jr_target[1:0] != 2'b00);

  assign timeoutHit = (TIMEOUT_CYCLES != 0) &&
    (timeoutCnt == TIMEOUT_CYCLES - 1);

  // an instruction retires when EXEC is released by stall
  assign retire = (state == EXEC) & ~stall;

  // next-PC select, jr highest priority
  always_comb begin
    nextPc = pcPlus4;
    if (jr) begin
      nextPc = jr_target;
    end else if (jump | jal) begin
      nextPc = jumpTarget;
    end else if (branchTaken) begin
      nextPc = branchTarget;
    end
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        stateNext = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          stateNext = EXEC;
        end else if (timeoutHit) begin
          stateNext = ERROR;
        end
      end
      EXEC: begin
        if (!stall) begin
          stateNext = jrMisaligned ? ERROR : FETCH;
        end
      end
      ERROR: begin
        stateNext = ERROR;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // fetch wait counter, cleared on ack or leaving FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      timeoutCnt <= '0;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        timeoutCnt <= '0;
      end else begin
        timeoutCnt <= timeoutCnt + 32'd1;
      end
    end else begin
      timeoutCnt <= '0;
    end
  end

  // instruction register, loaded only in the ack cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      instrReg <= '0;
    end else if (state == FETCH && imem_ack) begin
      instrReg <= imem_rdata;
    end
  end

  // program counter, advanced when an instruction retires
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= RESET_PC;
    end else if (retire && !jrMisaligned) begin
      pcReg <= nextPc;
    end
  end

  assign imem_req    = (state == FETCH) & ~reset;
  assign instr_valid = (state == EXEC) & ~reset;
  assign fetch_error = (state == ERROR) & ~reset;
  assign imem_addr   = pcReg;
  assign instr       = instrReg;
  assign pc          = pcReg;
  assign pc_plus4    = pcPlus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: vector table, corner sequences
// and a randomized run against a next-PC reference model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        jal = 1'b0;
  logic        alu_zero = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        fetch_error;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .stall(stall), .branch(branch), .jump(jump),
    .jal(jal), .alu_zero(alu_zero), .jr(jr),
    .jr_target(jr_target), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        br;
    logic        jp;
    logic        jl;
    logic        z;
    logic        jrr;
    logic [31:0] jrt;
    logic [31:0] expPc;
  } vecT;

  vecT vecs[12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtl();
    stall = 0; branch = 0; jump = 0; jal = 0;
    alu_zero = 0; jr = 0; jr_target = '0;
    imem_ack = 0;
  endtask

  task automatic doReset();
    clearCtl();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic waitReq();
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      step();
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL waitReq actual 0 required 1");
    end
  endtask

  task automatic fetchWord(input logic [31:0] w);
    imem_ack = 1;
    imem_rdata = w;
    step();
    imem_ack = 0;
    imem_rdata = 32'h0BAD_F00D;
  endtask

  task automatic execCtl(input logic b, input logic j,
                         input logic l, input logic z,
                         input logic r,
                         input logic [31:0] t);
    stall = 0; imem_ack = 0;
    branch = b; jump = j; jal = l;
    alu_zero = z; jr = r; jr_target = t;
    step();
    clearCtl();
  endtask

  function automatic logic [31:0] refNext(
    input logic [31:0] p, input logic [31:0] ins,
    input logic b, input logic j, input logic l,
    input logic z, input logic r,
    input logic [31:0] t);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (r) return t;
    if (j | l)
      return (p4 & 32'hF000_0000) + ({6'd0, ins[25:0]} * 4);
    off = $signed(ins[15:0]);
    if (b && ((ins[26] == 1'b1) ? !z : z))
      return p4 + 32'(off * 4);
    return p4;
  endfunction

  initial begin
    logic [31:0] mpc;
    logic [31:0] w;
    logic [31:0] t;
    logic        b, j, l, z, r, bad;
    int          d, k;

    vecs[0]  = '{32'h0040_0000, 32'h2008_0005,
                 0, 0, 0, 0, 0, 0, 32'h0040_0004};
    vecs[1]  = '{32'h0040_0010, 32'h1000_FFFF,
                 1, 0, 0, 1, 0, 0, 32'h0040_0010};
    vecs[2]  = '{32'h0040_0010, 32'h1400_FFFF,
                 1, 0, 0, 1, 0, 0, 32'h0040_0014};
    vecs[3]  = '{32'h0040_0020, 32'h0C10_0008,
                 0, 0, 1, 0, 0, 0, 32'h0040_0020};
    vecs[4]  = '{32'h0040_0020, 32'h0C10_0008,
                 0, 1, 0, 0, 1, 32'h0040_0024,
                 32'h0040_0024};
    vecs[5]  = '{32'h0040_0010, 32'h1000_FFFF,
                 1, 0, 0, 0, 0, 0, 32'h0040_0014};
    vecs[6]  = '{32'hFFFF_FFFC, 32'h2008_0005,
                 0, 0, 0, 0, 0, 0, 32'h0000_0000};
    vecs[7]  = '{32'hFFFF_FFF8, 32'h1000_0001,
                 1, 0, 0, 1, 0, 0, 32'h0000_0000};
    vecs[8]  = '{32'hF000_0000, 32'h0800_0003,
                 0, 1, 0, 0, 0, 0, 32'hF000_000C};
    vecs[9]  = '{32'h0040_0100, 32'h1400_0010,
                 1, 0, 0, 0, 0, 0, 32'h0040_0144};
    vecs[10] = '{32'h0040_0100, 32'h1400_0010,
                 0, 0, 0, 0, 0, 0, 32'h0040_0104};
    vecs[11] = '{32'h1FFF_FFFC, 32'h0800_0001,
                 0, 1, 0, 0, 0, 0, 32'h2000_0004};

    // reset behaviour
    step();
    check("rst_req", {31'd0, imem_req}, 0);
    check("rst_valid", {31'd0, instr_valid}, 0);
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, 0);
    check("rst_err", {31'd0, fetch_error}, 0);
    reset = 0;
    check("idle_req", {31'd0, imem_req}, 0);
    step();
    check("fetch_req", {31'd0, imem_req}, 1);
    check("fetch_addr", imem_addr, RPC);
    check("fetch_valid", {31'd0, instr_valid}, 0);

    // reset in the middle of an acked fetch
    fetchWord(32'h0);
    execCtl(0, 0, 0, 0, 1, 32'h0000_1000);
    waitReq();
    check("jr_addr", imem_addr, 32'h0000_1000);
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    reset = 1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 0);
    step();
    reset = 0;
    imem_ack = 0;
    check("midrst_instr", instr, 0);
    check("midrst_pc", pc, RPC);
    check("midrst_valid", {31'd0, instr_valid}, 0);
    check("midrst_req2", {31'd0, imem_req}, 0);
    step();
    check("midrst_req3", {31'd0, imem_req}, 1);

    // vector table
    for (int i = 0; i < 12; i++) begin
      doReset();
      waitReq();
      fetchWord(32'h0);
      execCtl(0, 0, 0, 0, 1, vecs[i].pc);
      waitReq();
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc);
      fetchWord(vecs[i].ins);
      check($sformatf("v%0d_valid", i),
            {31'd0, instr_valid}, 1);
      check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d_p4", i), pc_plus4,
            vecs[i].pc + 32'd4);
      check($sformatf("v%0d_instr", i), instr, vecs[i].ins);
      execCtl(vecs[i].br, vecs[i].jp, vecs[i].jl,
              vecs[i].z, vecs[i].jrr, vecs[i].jrt);
      waitReq();
      check($sformatf("v%0d_next", i), imem_addr,
            vecs[i].expPc);
    end

    // zero-wait memory: one instruction every two cycles
    doReset();
    waitReq();
    imem_ack = 1;
    imem_rdata = 32'h2008_0005;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("zw_valid%0d", i), {31'd0, instr_valid},
            (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0)
        check($sformatf("zw_pc%0d", i), pc,
              RPC + 32'(4 * (i / 2)));
    end
    imem_ack = 0;

    // timeout after 16 fetch cycles without ack
    doReset();
    waitReq();
    repeat (15) step();
    check("to15_err", {31'd0, fetch_error}, 0);
    check("to15_req", {31'd0, imem_req}, 1);
    step();
    check("to16_err", {31'd0, fetch_error}, 1);
    check("to16_req", {31'd0, imem_req}, 0);
    imem_ack = 1;
    imem_rdata = 32'h2008_0005;
    repeat (3) step();
    imem_ack = 0;
    check("late_err", {31'd0, fetch_error}, 1);
    check("late_valid", {31'd0, instr_valid}, 0);
    check("late_req", {31'd0, imem_req}, 0);
    doReset();
    check("clr_err", {31'd0, fetch_error}, 0);
    waitReq();
    repeat (15) step();
    fetchWord(32'h2008_0005);
    check("ack15_err", {31'd0, fetch_error}, 0);
    check("ack15_valid", {31'd0, instr_valid}, 1);
    check("ack15_instr", instr, 32'h2008_0005);

    // stall holds the execute cycle
    doReset();
    waitReq();
    fetchWord(32'h2008_0005);
    stall = 1;
    jump = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("st%0d_valid", i),
            {31'd0, instr_valid}, 1);
      check($sformatf("st%0d_pc", i), pc, RPC);
    end
    jump = 0;
    stall = 0;
    step();
    check("st_req", {31'd0, imem_req}, 1);
    check("st_addr", imem_addr, RPC + 32'd4);

    // misaligned jr
    doReset();
    waitReq();
    fetchWord(32'h0);
    execCtl(0, 0, 0, 0, 1, 32'h0040_0002);
    check("jrmis_err", {31'd0, fetch_error}, 1);
    check("jrmis_req", {31'd0, imem_req}, 0);

    // randomized run against the reference model
    doReset();
    mpc = RPC;
    for (int it = 0; it < 300; it++) begin
      waitReq();
      d = $urandom_range(0, 4);
      for (int c = 0; c < d; c++) begin
        step();
      end
      check("rnd_req", {31'd0, imem_req}, 1);
      check("rnd_addr", imem_addr, mpc);
      w = $urandom;
      fetchWord(w);
      check("rnd_instr", instr, w);
      check("rnd_pc", pc, mpc);
      check("rnd_p4", pc_plus4, mpc + 32'd4);
      k = $urandom_range(0, 2);
      for (int c = 0; c < k; c++) begin
        stall = 1;
        imem_ack = 1'($urandom);
        imem_rdata = $urandom;
        step();
        check("rnd_stvalid", {31'd0, instr_valid}, 1);
        check("rnd_stinstr", instr, w);
      end
      b = 1'($urandom);
      j = ($urandom_range(0, 5) == 0);
      l = ($urandom_range(0, 5) == 0);
      z = 1'($urandom);
      r = ($urandom_range(0, 7) == 0);
      bad = r && ($urandom_range(0, 3) == 0);
      t = $urandom;
      t[1:0] = bad ? 2'($urandom_range(1, 3)) : 2'b00;
      execCtl(b, j, l, z, r, t);
      if (bad) begin
        check("rnd_err", {31'd0, fetch_error}, 1);
        doReset();
        mpc = RPC;
      end else begin
        check("rnd_noerr", {31'd0, fetch_error}, 0);
        mpc = refNext(mpc, w, b, j, l, z, r, t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
